// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
// Purpose : groups the spike-stream handshake and the SNN core bus driven by
//           core_sequencer into one bundle.
// Signals : spk_valid_i / spk_addr_i[8:0] / spk_last_i / spk_ready_o
//             - upstream spike stream (valid/ready, last marks end of step)
//           core_ack_i    - core pulse, send-spike step finished
//           addr_o[8:0] / we_o / en_o
//             - core address / write enable / enable
// Modports: master - the sequencer side
//           slave  - the environment side (spike source + core)
// -----------------------------------------------------------------------------
interface core_sequencer_if;
    logic       spk_valid_i;
    logic [8:0] spk_addr_i;
    logic       spk_last_i;
    logic       spk_ready_o;
    logic       core_ack_i;
    logic [8:0] addr_o;
    logic       we_o;
    logic       en_o;

    modport master (
        input  spk_valid_i, spk_addr_i, spk_last_i, core_ack_i,
        output spk_ready_o, addr_o, we_o, en_o
    );

    modport slave (
        output spk_valid_i, spk_addr_i, spk_last_i, core_ack_i,
        input  spk_ready_o, addr_o, we_o, en_o
    );
endinterface

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Purpose : bus master that runs one picture through the SNN core: selects
//           the weight set, then for each time step writes the step's spike
//           addresses, fires a send-spike read and waits for the core's ack,
//           and finally writes done_pic.
// Ports   : clk, rst        - clock (rising edge), async active-high reset
//           start_i         - start a picture (only honoured in IDLE)
//           weight_sel_i[3:0] - weight set, taken with an accepted start
//           bus (master)    - spike stream + core address/we/en/ack
//           busy_o          - picture in progress (CFG through DONE)
//           step_o          - current time step index
//           done_o          - one-cycle pulse with the done_pic write
//           err_o           - sticky illegal-spike-address flag
// All outputs are registered: the comb block computes the values for the
// next cycle and the register block loads them together with the state.
// -----------------------------------------------------------------------------
module core_sequencer #(
    parameter int  NUM_STEPS      = 16,
    parameter int  DONE_PIC_ADDR  = 448,
    parameter int  CW_BASE        = 464,
    parameter int  MAX_SPIKE_ADDR = 447,
    parameter int  FIRE_ADDR      = 0,
    localparam int STEP_W         = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [3:0]        weight_sel_i,
    core_sequencer_if.master  bus,
    output logic              busy_o,
    output logic [STEP_W-1:0] step_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD, S_FIRE, S_WAIT, S_DONE
    } state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_t            r_state,   w_state_nx;
    logic              r_fire_rd, w_fire_rd_nx;  // FIRE second cycle (read issued)
    logic [8:0]        r_addr,    w_addr_nx;
    logic              r_we,      w_we_nx;
    logic              r_en,      w_en_nx;
    logic              r_ready,   w_ready_nx;
    logic              r_busy,    w_busy_nx;
    logic              r_done,    w_done_nx;
    logic              r_err,     w_err_nx;
    logic [STEP_W-1:0] r_step,    w_step_nx;

    logic w_hs;
    logic w_spk_legal;

    // Ready is only ever high in LOAD, so the handshake implies LOAD.
    assign w_hs        = bus.spk_valid_i & r_ready;
    assign w_spk_legal = (bus.spk_addr_i <= 9'(MAX_SPIKE_ADDR));

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_state_nx   = r_state;
        w_fire_rd_nx = 1'b0;
        w_addr_nx    = 9'd0;
        w_we_nx      = 1'b0;
        w_en_nx      = 1'b0;
        w_ready_nx   = 1'b0;
        w_done_nx    = 1'b0;
        w_err_nx     = r_err;
        w_step_nx    = r_step;

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nx = S_CFG;
                    w_en_nx    = 1'b1;
                    w_we_nx    = 1'b1;
                    w_addr_nx  = 9'(CW_BASE) + {5'd0, weight_sel_i};
                    w_step_nx  = '0;
                    w_err_nx   = 1'b0;
                end
            end

            S_CFG: begin
                w_state_nx = S_LOAD;
                w_ready_nx = 1'b1;
            end

            S_LOAD: begin
                w_ready_nx = 1'b1;
                if (w_hs) begin
                    if (w_spk_legal) begin
                        w_en_nx   = 1'b1;
                        w_we_nx   = 1'b1;
                        w_addr_nx = bus.spk_addr_i;
                    end else if (!bus.spk_last_i) begin
                        w_err_nx = 1'b1;
                    end
                    // An out-of-range last beat is a null terminator: it only
                    // closes the step.
                    if (bus.spk_last_i) begin
                        w_state_nx = S_FIRE;
                        w_ready_nx = 1'b0;
                    end
                end
            end

            // First FIRE cycle carries the last spike write; the second carries
            // the send-spike read.
            S_FIRE: begin
                if (!r_fire_rd) begin
                    w_fire_rd_nx = 1'b1;
                    w_en_nx      = 1'b1;
                    w_addr_nx    = 9'(FIRE_ADDR);
                end else begin
                    w_state_nx = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.core_ack_i) begin
                    if (r_step == LAST_STEP) begin
                        w_state_nx = S_DONE;
                        w_en_nx    = 1'b1;
                        w_we_nx    = 1'b1;
                        w_addr_nx  = 9'(DONE_PIC_ADDR);
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_LOAD;
                        w_step_nx  = r_step + 1'b1;
                        w_ready_nx = 1'b1;
                    end
                end
            end

            S_DONE: begin
                w_state_nx = S_IDLE;
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_fire_rd <= 1'b0;
            r_addr    <= 9'd0;
            r_we      <= 1'b0;
            r_en      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_step    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_fire_rd <= w_fire_rd_nx;
            r_addr    <= w_addr_nx;
            r_we      <= w_we_nx;
            r_en      <= w_en_nx;
            r_ready   <= w_ready_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
            r_step    <= w_step_nx;
        end
    end

    assign bus.addr_o      = r_addr;
    assign bus.we_o        = r_we;
    assign bus.en_o        = r_en;
    assign bus.spk_ready_o = r_ready;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;
    assign step_o          = r_step;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Bus master that sequences one picture through the SNN core's 9-bit address/we/en port. It follows the core memory map: slice spike writes at 0–447, send-spike broadcast as a read with addr[8]=0, choose_weight writes at 464–479, done_pic write at 448. For each picture it configures the weight set, then runs NUM_STEPS time steps. Each step loads that step's spike addresses from an upstream valid/ready stream, fires a send-spike broadcast and waits for the core's acknowledge. It finishes with the done_pic write.

Parameters:
NUM_STEPS, 16, time steps per picture (≥1); step counter width = clog2(NUM_STEPS), min 1
DONE_PIC_ADDR, 448, done_pic address
CW_BASE, 464, choose_weight base; weight select added to it
MAX_SPIKE_ADDR, 447, highest legal spike write address
FIRE_ADDR, 0, address used for the send-spike read (must have bit 8 = 0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  start picture; sampled only in IDLE
weight_sel_i  in  4  weight set; captured on accepted start
spk_valid_i  in  1  spike stream valid
spk_addr_i  in  9  spike neuron address
spk_last_i  in  1  last spike of current time step
spk_ready_o  out  1  spike stream ready
core_ack_i  in  1  core pulse: send-spike step finished
addr_o  out  9  core address
we_o  out  1  core write enable
en_o  out  1  core enable
busy_o  out  1  high from the cycle after accepted start until done_o cycle inclusive
step_o  out  clog2(NUM_STEPS)  current time step index
done_o  out  1  one-cycle pulse, picture complete
err_o  out  1  sticky: illegal spike address seen; cleared on next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; addr_o=0, we_o=0, en_o=0, spk_ready_o=0, busy_o=0, step_o=0, done_o=0, err_o=0. A reset mid-picture abandons it. No done write is issued.
- All outputs are registered. en_o is high for exactly one cycle per bus access. addr_o and we_o are don't-care-free: both read 0 when en_o=0.
- States: IDLE, CFG, LOAD, FIRE, WAIT, DONE.
- IDLE: start_i=1 at edge k → capture weight_sel_i, clear err_o and step, go to CFG. start_i in any other state is ignored.
- CFG: one cycle with en_o=1, we_o=1, addr_o=CW_BASE+weight_sel (9-bit, no wrap for 0–15). Next state is LOAD.
- LOAD: spk_ready_o=1. A handshake (valid&ready) at edge k drives a write in cycle k+1 with en_o=we_o=1 and addr_o=spk_addr_i. Throughput is 1 spike/cycle back-to-back.
- Illegal address (spk_addr_i > MAX_SPIKE_ADDR): no bus access in k+1.
  - If spk_last_i=0, err_o is set.
  - If spk_last_i=1, the beat is a legal "empty/null terminator": no write and no error.
- A handshake with spk_last_i=1 moves the state to FIRE. spk_ready_o drops in the cycle after that handshake.
- FIRE: entered the cycle after the last beat is accepted, so the last spike's write occupies that same cycle. The following cycle is the send-spike read: en_o=1, we_o=0, addr_o=FIRE_ADDR. Then go to WAIT. Net result: two cycles in FIRE.
- WAIT: no bus activity; spk_ready_o=0.
  - On core_ack_i=1: if step==NUM_STEPS-1, go to DONE; otherwise step++ and go to LOAD.
  - core_ack_i outside WAIT is ignored.
  - No timeout.
- DONE: one cycle with en_o=1, we_o=1, addr_o=DONE_PIC_ADDR, done_o=1, then IDLE. busy_o falls the cycle after.
- step_o holds its final value (NUM_STEPS-1) in IDLE until the next start clears it.
- Bus accesses never overlap. At most one en_o cycle per clock.

Test Plan:
- Reset mid-LOAD: assert rst asynchronously between edges → all outputs 0 immediately; a later start runs from CFG with step_o=0.
- Basic picture, NUM_STEPS=2, weight_sel=5, start:
  - en writes at 469.
  - Step 0: spikes 3, 10, 447(last) → writes 3, 10, 447 on consecutive cycles, then read at 0. ack → step_o=1.
  - Step 1: spike 7(last) → write 7, read 0. ack → write 448 with done_o=1, then busy_o=0.
- Backpressure/throughput: spk_valid_i held high with 4 spikes → exactly 4 consecutive write cycles, no gaps. spk_valid_i gaps → writes follow valid with 1-cycle latency.
- Illegal addresses:
  - spike 500 (not last) → no write, err_o=1 and it stays high through done.
  - null terminator 511 with last=1 → no write, err_o unchanged, FIRE read issued.
  - next start → err_o=0.
- Ignored events:
  - start_i pulsed during WAIT → no effect.
  - core_ack_i pulsed during LOAD → no step advance.
  - ack held 3 cycles in WAIT → advances exactly one step.
- Latency check: start at edge 0 → CFG en_o in cycle 1; spk_ready_o=1 from cycle 2; last handshake at edge k → last write in cycle k+1, send-spike read in cycle k+2.
